// File: rtl/stage5_mem_stage_if.sv
// Data bus between the memory stage (master) and data memory (slave).
// The request side stays stable until the slave drops busy.
interface stage5_mem_stage_if;
  logic        dbus_ren;
  logic        dbus_wen;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byte_en;
  logic        dbus_busy;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_ren, dbus_wen, dbus_addr,
    output dbus_wdata, dbus_byte_en,
    input  dbus_busy, dbus_rdata
  );

  modport slave (
    input  dbus_ren, dbus_wen, dbus_addr,
    input  dbus_wdata, dbus_byte_en,
    output dbus_busy, dbus_rdata
  );
endinterface

// File: rtl/stage5_mem_stage.sv
// MEM stage: data bus loads/stores with busy stall, MEM/WB register,
// and fetch redirect for taken branches and serialising flushes.
module stage5_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wen,
  input  logic        ex_mem_ren,
  input  logic        ex_mem_wen,
  input  logic [1:0]  ex_size,
  input  logic        ex_load_unsigned,
  input  logic        ex_brj_taken,
  input  logic [31:0] ex_brj_target,
  input  logic        ex_flush_req,
  output logic        ex_ready,
  stage5_mem_stage_if.master dbus,
  output logic [31:0] brj_addr,
  output logic [31:0] pc4,
  output logic        redirect,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_wen,
  output logic [31:0] wb_data,
  output logic        wb_misaligned
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic        misal;
  logic        issue;
  logic        req;
  logic        done;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] lane;
  logic [31:0] ld;

  logic        hold_ren;
  logic        hold_wen;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_be;

  assign misal = (ex_size == 2'b01 && ex_addr[0])
              || (ex_size[1] && ex_addr[1:0] != 2'b00);
  assign issue = ex_valid && !misal
              && (ex_mem_ren || ex_mem_wen);

  always_comb begin
    be = 4'b1111;
    wd = ex_store_data;
    unique case (1'b1)
      (ex_size == 2'b00): begin
        be = 4'b0001 << ex_addr[1:0];
        wd = {4{ex_store_data[7:0]}};
      end
      (ex_size == 2'b01): begin
        be = ex_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // In WAIT the bus sees the captured request, not live EX inputs.
  always_comb begin
    dbus.dbus_ren     = 1'b0;
    dbus.dbus_wen     = 1'b0;
    dbus.dbus_addr    = '0;
    dbus.dbus_wdata   = '0;
    dbus.dbus_byte_en = '0;
    if (state == WAIT) begin
      dbus.dbus_ren     = hold_ren;
      dbus.dbus_wen     = hold_wen;
      dbus.dbus_addr    = hold_addr;
      dbus.dbus_wdata   = hold_wdata;
      dbus.dbus_byte_en = hold_be;
    end else if (issue) begin
      dbus.dbus_ren     = ex_mem_ren;
      dbus.dbus_wen     = ex_mem_wen;
      dbus.dbus_addr    = {ex_addr[31:2], 2'b00};
      dbus.dbus_wdata   = wd;
      dbus.dbus_byte_en = be;
    end
    if (RST) begin
      dbus.dbus_ren = 1'b0;
      dbus.dbus_wen = 1'b0;
    end
  end

  assign req      = dbus.dbus_ren || dbus.dbus_wen;
  assign ex_ready = !req || !dbus.dbus_busy;
  assign done     = ex_valid && !RST && ex_ready;

  assign lane = dbus.dbus_rdata >> {ex_addr[1:0], 3'b000};

  always_comb begin
    ld = lane;
    unique case (1'b1)
      (ex_size == 2'b00):
        ld = {{24{!ex_load_unsigned && lane[7]}}, lane[7:0]};
      (ex_size == 2'b01):
        ld = {{16{!ex_load_unsigned && lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      hold_ren      <= 1'b0;
      hold_wen      <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      hold_be       <= '0;
      brj_addr      <= RESET_PC;
      pc4           <= RESET_PC;
      redirect      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_wen    <= 1'b0;
      wb_data       <= '0;
      wb_misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req && dbus.dbus_busy) begin
          state      <= WAIT;
          hold_ren   <= dbus.dbus_ren;
          hold_wen   <= dbus.dbus_wen;
          hold_addr  <= dbus.dbus_addr;
          hold_wdata <= dbus.dbus_wdata;
          hold_be    <= dbus.dbus_byte_en;
        end
        WAIT: if (!dbus.dbus_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
      wb_valid <= done;
      redirect <= done && (ex_brj_taken || ex_flush_req);
      if (done) begin
        wb_rd         <= ex_rd;
        wb_reg_wen    <= ex_reg_wen && !misal;
        wb_misaligned <= misal;
        wb_data       <= (ex_mem_ren && !misal) ? ld : ex_addr;
        if (ex_brj_taken)
          brj_addr <= ex_brj_target;
        else if (ex_flush_req)
          pc4 <= ex_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_stage5_mem_stage.sv
// Directed bench for the MEM stage: loads, stores, stalls,
// misalignment, redirects and reset during an outstanding transfer.
module tb_stage5_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen;
  logic        ex_mem_ren;
  logic        ex_mem_wen;
  logic [1:0]  ex_size;
  logic        ex_load_unsigned;
  logic        ex_brj_taken;
  logic [31:0] ex_brj_target;
  logic        ex_flush_req;
  logic        ex_ready;
  logic [31:0] brj_addr;
  logic [31:0] pc4;
  logic        redirect;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_wen;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  int total = 0;
  int bad   = 0;

  stage5_mem_stage_if bus ();

  stage5_mem_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_addr          (ex_addr),
    .ex_store_data    (ex_store_data),
    .ex_rd            (ex_rd),
    .ex_reg_wen       (ex_reg_wen),
    .ex_mem_ren       (ex_mem_ren),
    .ex_mem_wen       (ex_mem_wen),
    .ex_size          (ex_size),
    .ex_load_unsigned (ex_load_unsigned),
    .ex_brj_taken     (ex_brj_taken),
    .ex_brj_target    (ex_brj_target),
    .ex_flush_req     (ex_flush_req),
    .ex_ready         (ex_ready),
    .dbus             (bus),
    .brj_addr         (brj_addr),
    .pc4              (pc4),
    .redirect         (redirect),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_reg_wen       (wb_reg_wen),
    .wb_data          (wb_data),
    .wb_misaligned    (wb_misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ex_valid         = 1'b0;
    ex_pc            = '0;
    ex_addr          = '0;
    ex_store_data    = '0;
    ex_rd            = '0;
    ex_reg_wen       = 1'b0;
    ex_mem_ren       = 1'b0;
    ex_mem_wen       = 1'b0;
    ex_size          = 2'b10;
    ex_load_unsigned = 1'b0;
    ex_brj_taken     = 1'b0;
    ex_brj_target    = '0;
    ex_flush_req     = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz,
                    input logic uns, input logic [4:0] rd);
    idle();
    ex_valid = 1'b1; ex_addr = a; ex_size = sz;
    ex_load_unsigned = uns; ex_rd = rd;
    ex_reg_wen = 1'b1; ex_mem_ren = 1'b1;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] d);
    idle();
    ex_valid = 1'b1; ex_addr = a; ex_size = sz;
    ex_store_data = d; ex_mem_wen = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    bus.dbus_busy  = 1'b0;
    bus.dbus_rdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_brj", brj_addr, 32'h200);
    chk("rst_pc4", pc4, 32'h200);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_redir", {31'd0, redirect}, 32'd0);
    chk("rst_ren", {31'd0, bus.dbus_ren}, 32'd0);
    chk("rst_rdy", {31'd0, ex_ready}, 32'd1);

    // lb signed, top lane
    @(negedge CLK);
    ld(32'h1003, 2'b00, 1'b0, 5'd5);
    bus.dbus_rdata = 32'h80FF_1234;
    #1;
    chk("lb_ren", {31'd0, bus.dbus_ren}, 32'd1);
    chk("lb_be", {28'd0, bus.dbus_byte_en}, 32'h8);
    chk("lb_addr", bus.dbus_addr, 32'h1000);
    chk("lb_rdy", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_rd}, 32'd5);
    chk("lb_wen", {31'd0, wb_reg_wen}, 32'd1);

    @(negedge CLK);
    ld(32'h1003, 2'b00, 1'b1, 5'd6);
    tick();
    chk("lbu_data", wb_data, 32'h0000_0080);

    @(negedge CLK);
    ld(32'h1002, 2'b01, 1'b0, 5'd7);
    #1;
    chk("lh_be", {28'd0, bus.dbus_byte_en}, 32'hC);
    tick();
    chk("lh_data", wb_data, 32'hFFFF_80FF);

    // stores
    @(negedge CLK);
    st(32'h2002, 2'b01, 32'h0000_ABCD);
    #1;
    chk("sh_wen", {31'd0, bus.dbus_wen}, 32'd1);
    chk("sh_ren", {31'd0, bus.dbus_ren}, 32'd0);
    chk("sh_be", {28'd0, bus.dbus_byte_en}, 32'hC);
    chk("sh_wd", bus.dbus_wdata, 32'hABCD_ABCD);
    tick();
    chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
    chk("sh_rwen", {31'd0, wb_reg_wen}, 32'd0);

    @(negedge CLK);
    st(32'h3001, 2'b00, 32'h1234_5677);
    #1;
    chk("sb_be", {28'd0, bus.dbus_byte_en}, 32'h2);
    chk("sb_wd", bus.dbus_wdata, 32'h7777_7777);
    tick();

    // lw stalled for 3 cycles
    @(negedge CLK);
    ld(32'h1004, 2'b10, 1'b0, 5'd9);
    bus.dbus_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      chk($sformatf("lw_stall_rdy%0d", i), {31'd0, ex_ready}, 32'd0);
      chk($sformatf("lw_stall_ren%0d", i), {31'd0, bus.dbus_ren}, 32'd1);
      chk($sformatf("lw_stall_a%0d", i), bus.dbus_addr, 32'h1004);
      chk($sformatf("lw_stall_be%0d", i), {28'd0, bus.dbus_byte_en}, 32'hF);
      tick();
      chk($sformatf("lw_stall_wbv%0d", i), {31'd0, wb_valid}, 32'd0);
    end
    @(negedge CLK);
    bus.dbus_busy  = 1'b0;
    bus.dbus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_rel_rdy", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("lw_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lw_data", wb_data, 32'hDEAD_BEEF);
    @(negedge CLK);
    idle();
    tick();
    chk("lw_nodup", {31'd0, wb_valid}, 32'd0);

    // misaligned word load
    @(negedge CLK);
    ld(32'h1001, 2'b10, 1'b0, 5'd3);
    #1;
    chk("mis_ren", {31'd0, bus.dbus_ren}, 32'd0);
    chk("mis_rdy", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
    chk("mis_flag", {31'd0, wb_misaligned}, 32'd1);
    chk("mis_rwen", {31'd0, wb_reg_wen}, 32'd0);

    // ALU result passes through
    @(negedge CLK);
    idle();
    ex_valid = 1'b1; ex_addr = 32'h1234_5678;
    ex_rd = 5'd11; ex_reg_wen = 1'b1;
    tick();
    chk("alu_data", wb_data, 32'h1234_5678);
    chk("alu_mis", {31'd0, wb_misaligned}, 32'd0);

    // branch + flush: branch wins
    @(negedge CLK);
    idle();
    ex_valid = 1'b1; ex_pc = 32'h100;
    ex_brj_taken = 1'b1; ex_brj_target = 32'h400;
    ex_flush_req = 1'b1;
    tick();
    chk("brj_redir", {31'd0, redirect}, 32'd1);
    chk("brj_addr", brj_addr, 32'h400);
    chk("brj_pc4", pc4, 32'h200);
    @(negedge CLK);
    idle();
    tick();
    chk("brj_pulse", {31'd0, redirect}, 32'd0);
    chk("brj_hold", brj_addr, 32'h400);

    // flush at top of address space wraps
    @(negedge CLK);
    idle();
    ex_valid = 1'b1; ex_pc = 32'hFFFF_FFFC;
    ex_flush_req = 1'b1;
    tick();
    chk("fl_redir", {31'd0, redirect}, 32'd1);
    chk("fl_pc4", pc4, 32'h0);
    chk("fl_brj", brj_addr, 32'h400);

    // reset while a load waits on the bus
    @(negedge CLK);
    ld(32'h1008, 2'b10, 1'b0, 5'd4);
    bus.dbus_busy = 1'b1;
    tick();
    @(negedge CLK);
    RST = 1'b1;
    idle();
    tick();
    chk("rw_ren", {31'd0, bus.dbus_ren}, 32'd0);
    chk("rw_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rw_brj", brj_addr, 32'h200);
    chk("rw_pc4", pc4, 32'h200);
    @(negedge CLK);
    RST = 1'b0;
    bus.dbus_busy  = 1'b0;
    bus.dbus_rdata = 32'h0BAD_F00D;
    ld(32'h100C, 2'b10, 1'b0, 5'd8);
    #1;
    chk("rw_idle_rdy", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("rw_idle_wbv", {31'd0, wb_valid}, 32'd1);
    chk("rw_idle_data", wb_data, 32'h0BAD_F00D);

    @(negedge CLK);
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
